serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting operand and result width in bits.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have input start, 1 bit, a request to begin an operation.
REQ-005 The block SHALL have inputs a and b, each WIDTH bits, the operands, sampled only when start is accepted.
REQ-006 The block SHALL have input sub, 1 bit: 1 selects a-b, 0 selects a+b; sampled only when start is accepted.
REQ-007 The block SHALL have outputs fa_a, fa_b and fa_cin, 1 bit each, driving the 1-bit full adder's ai, bi and cini.
REQ-008 The block SHALL have inputs fa_s and fa_cout, 1 bit each, taken from the full adder's si and couti.
REQ-009 The block SHALL have output sum, WIDTH bits, the result register.
REQ-010 The block SHALL have outputs cout and ovf, 1 bit each: final carry-out and signed overflow.
REQ-011 The block SHALL have output busy, 1 bit, high whenever state is not IDLE.
REQ-012 The block SHALL have output done, 1 bit, a one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE on the edge that processes bit WIDTH-1; DONE->IDLE unconditionally.
REQ-014 When start=1 in IDLE, the block SHALL load a and b into shift registers, load carry := effective sub, clear bit counter to 0 and clear sum, cout and ovf.
REQ-015 start SHALL be ignored in RUN and DONE, with no queuing and no effect on the operation in progress.
REQ-016 In RUN: fa_a = a_sr[0]; fa_b = b_sr[0] XOR effective sub; fa_cin = carry register; all three are combinational from registers.
REQ-017 In IDLE and DONE, fa_a, fa_b and fa_cin SHALL be 0.
REQ-018 On each RUN edge: shift a_sr and b_sr right by 1; shift fa_s into sum MSB with sum shifted right; carry := fa_cout; counter +1.
REQ-019 On the edge processing bit WIDTH-1, the block SHALL set cout := fa_cout and ovf := fa_cin XOR fa_cout.
REQ-020 Latency: start accepted at edge E0; RUN occupies edges E1..E(WIDTH); done=1 for exactly the cycle after E(WIDTH).
REQ-021 sum, cout and ovf SHALL be valid from the done cycle and held until the next accepted start.
REQ-022 The counter SHALL be exactly clog2(WIDTH) bits and wrap to 0 at the DONE transition; no other wrap is permitted.
REQ-023 For subtraction, cout=1 SHALL mean no borrow (two's-complement carry); cout SHALL NOT be inverted.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; sum is the low WIDTH bits.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for a clock edge, force state to IDLE and clear sum, cout, ovf, carry, counter and the shift registers.
REQ-026 During and after reset, busy, done, fa_a, fa_b and fa_cin SHALL be 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the next start after rst deasserts SHALL run normally.
REQ-028 start sampled on the first edge after rst deasserts SHALL be accepted.

Configuration
REQ-029 The block SHALL compile subtraction support in or out with macro SERIAL_ADD_SUB_EN.
REQ-030 With SERIAL_ADD_SUB_EN defined, effective sub = the sampled sub input.
REQ-031 Without SERIAL_ADD_SUB_EN, effective sub SHALL be constant 0; the sub port remains present but is ignored; the port list is unchanged.

Verification
REQ-032 The bench SHALL apply start with a=0x35, b=0x4A, sub=0 -> sum=0x7F, cout=0, ovf=0; done exactly 8 cycles after the start edge; busy high for 9 cycles.
REQ-033 The bench SHALL apply a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0.
REQ-034 The bench SHALL apply a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, ovf=1.
REQ-035 With the macro defined, the bench SHALL apply a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0, ovf=0; without the macro, the same stimulus -> sum=0x30.
REQ-036 The bench SHALL pulse start again in RUN cycle 3 with different operands -> result unchanged from the first operands, and only one done pulse.
REQ-037 The bench SHALL assert rst in RUN cycle 4 -> busy=0 and sum=0 immediately, no done pulse; a following start a=0x01, b=0x02 -> sum=0x03.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract controller driving an external 1-bit full adder
// Define SERIAL_ADD_SUB_EN to compile in subtraction; otherwise the sub port is ignored.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_sub;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sub_in;
    logic             w_run;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub_in = sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_sub_in     = 1'b0;
`endif

    assign w_run = (r_state == RUN);

    // Adder inputs come straight from registers so the external adder sees a clean cycle.
    assign fa_a   = w_run & r_a_sr[0];
    assign fa_b   = w_run & (r_b_sr[0] ^ r_sub);
    assign fa_cin = w_run & r_carry;

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_sub   <= w_sub_in;
                        r_carry <= w_sub_in;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_sum   <= {fa_s, r_sum[WIDTH-1:1]};
                    r_carry <= fa_cout;
                    // Overflow is carry-into-MSB differing from carry-out-of-MSB.
                    if (r_cnt == LAST) begin
                        r_cout  <= fa_cout;
                        r_ovf   <= fa_cin ^ fa_cout;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl with a behavioural full adder
module tb_serial_add_ctrl;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       sub = 1'b0;
    logic       fa_a, fa_b, fa_cin, fa_s, fa_cout;
    logic [7:0] sum;
    logic       cout, ovf, busy, done;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

`ifdef SERIAL_ADD_SUB_EN
    localparam logic SUB_EFF = 1'b1;
`else
    localparam logic SUB_EFF = 1'b0;
`endif

    always #5 clk = ~clk;

    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    always @(negedge clk) if (done) done_cnt++;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic ms);
        exp_t       e;
        logic       eff;
        logic [7:0] bb;
        logic [8:0] r;
        eff = ms & SUB_EFF;
        bb  = eff ? ~mb : mb;
        r   = {1'b0, ma} + {1'b0, bb} + {8'd0, eff};
        e.s = r[7:0];
        e.c = r[8];
        e.o = (ma[7] == bb[7]) && (r[7] != ma[7]);
        return e;
    endfunction

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                         input exp_t e, input int intr_k, input int rst_k);
        int   done_k;
        int   busy_n;
        int   d0;
        exp_t got;
        exp_q.push_back(e);
        d0 = done_cnt;
        a = ta; b = tb_; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hAA; b = 8'h55; sub = ~ts;
        done_k = -1;
        busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 0) begin
                chk("fa_a_run", fa_a, ta[0]);
                chk("fa_b_run", fa_b, tb_[0] ^ (ts & SUB_EFF));
                chk("fa_cin_run", fa_cin, ts & SUB_EFF);
            end
            if (busy) busy_n++;
            if (done) begin
                if (done_k < 0) done_k = k;
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    chk("sum", sum, got.s);
                    chk("cout", cout, got.c);
                    chk("ovf", ovf, got.o);
                end
            end
            start = (k == intr_k);
            if (k == intr_k) begin
                a = 8'hC3; b = 8'h5A;
            end
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_sum", sum, 0);
                chk("rst_done", done, 0);
                chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
                void'(exp_q.pop_back());
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (!busy && k > 0) break;
            @(negedge clk);
        end
        start = 1'b0;
        if (rst_k < 0) begin
            chk("done_latency", done_k, 8);
            chk("busy_cycles", busy_n, 9);
            chk("done_pulses", done_cnt - d0, 1);
            chk("sum_held", sum, e.s);
        end else begin
            chk("no_done_on_abort", done_cnt - d0, 0);
        end
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        exp_t e;
        logic [7:0] ra, rb;
        logic       rs;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout_ovf", {cout, ovf}, 0);
        chk("reset_fa", {fa_a, fa_b, fa_cin}, 0);
        rst = 1'b0;

        e = '{s: 8'h7F, c: 1'b0, o: 1'b0};
        do_op(8'h35, 8'h4A, 1'b0, e, -1, -1);
        e = '{s: 8'h00, c: 1'b1, o: 1'b0};
        do_op(8'hFF, 8'h01, 1'b0, e, -1, -1);
        e = '{s: 8'h80, c: 1'b0, o: 1'b1};
        do_op(8'h7F, 8'h01, 1'b0, e, -1, -1);
`ifdef SERIAL_ADD_SUB_EN
        e = '{s: 8'hF0, c: 1'b0, o: 1'b0};
`else
        e = '{s: 8'h30, c: 1'b0, o: 1'b0};
`endif
        do_op(8'h10, 8'h20, 1'b1, e, -1, -1);

        e = '{s: 8'h46, c: 1'b0, o: 1'b0};
        do_op(8'h12, 8'h34, 1'b0, e, 2, -1);

        e = '{s: 8'h64, c: 1'b0, o: 1'b0};
        do_op(8'h55, 8'h0F, 1'b0, e, -1, 3);
        e = '{s: 8'h03, c: 1'b0, o: 1'b0};
        do_op(8'h01, 8'h02, 1'b0, e, -1, -1);

        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs, model(ra, rb, rs), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
